// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types for the commit-side branch/exception redirect controller.
package br_redirect_ctrl_pkg;

   localparam int unsigned PC_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_DS = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_REDIR   = 2'd3
   } state_e;

   typedef enum logic {
      SRC_BR  = 1'b0,
      SRC_EXC = 1'b1
   } src_e;

endpackage

// File: rtl/br_redirect_ctrl_flush_timer.sv
// Loadable down-counter; done_c_o marks the last cycle of a FLUSH_CYCLES window.
module br_redirect_ctrl_flush_timer #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   output logic done_c_o
);

   localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(FLUSH_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c_o = (cnt_q == CW'(1));

endmodule

// File: rtl/br_redirect_ctrl.sv
// Watches ROB commits; after a taken branch's delay slot (or any exception)
// flushes the back end and offers the new PC to fetch.
module br_redirect_ctrl
   import br_redirect_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_WD       = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmt_valid,
   input  logic              cmt_is_br,
   input  logic              cmt_br_e,
   input  logic [PC_W-1:0]   cmt_target,
   input  logic              cmt_exc,
   input  logic [PC_W-1:0]   exc_vector,
   output logic              cmt_ready,
   output logic              flush,
   output logic              redir_valid,
   output logic [PC_W-1:0]   redir_pc,
   input  logic              redir_ready,
   output logic [CNT_WD-1:0] br_taken_cnt
);

   state_e            state_q, state_d;
   src_e              src_q, src_d;
   logic              cmt_ready_q, cmt_ready_d;
   logic              flush_q, flush_d;
   logic              redir_valid_q, redir_valid_d;
   logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
   logic [PC_W-1:0]   pend_q, pend_d;
   logic [CNT_WD-1:0] cnt_q, cnt_d;

   logic fire;
   logic xfer;
   logic tmr_load;
   logic tmr_done;

   assign fire = cmt_valid & cmt_ready_q;
   assign xfer = redir_valid_q & redir_ready;

   br_redirect_ctrl_flush_timer #(
      .FLUSH_CYCLES(FLUSH_CYCLES)
   ) u_flush_timer (
      .clk      (clk),
      .rst_n    (resetn),
      .load_i   (tmr_load),
      .done_c_o (tmr_done)
   );

   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      cmt_ready_d   = cmt_ready_q;
      flush_d       = flush_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      pend_d        = pend_q;
      cnt_d         = cnt_q;
      tmr_load      = 1'b0;

      // Handshake completes independently of where the FSM is in FLUSH/REDIR.
      if (xfer) begin
         redir_valid_d = 1'b0;
         if (src_q == SRC_BR) begin
            cnt_d = cnt_q + CNT_WD'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (fire && cmt_exc) begin
               pend_d        = exc_vector;
               redir_pc_d    = exc_vector;
               src_d         = SRC_EXC;
               state_d       = ST_FLUSH;
               cmt_ready_d   = 1'b0;
               flush_d       = 1'b1;
               redir_valid_d = 1'b1;
               tmr_load      = 1'b1;
            end else if (fire && cmt_is_br && cmt_br_e) begin
               pend_d  = cmt_target;
               state_d = ST_WAIT_DS;
            end
         end
         ST_WAIT_DS: begin
            // Branch fields of the delay slot are deliberately ignored.
            if (fire) begin
               if (cmt_exc) begin
                  pend_d     = exc_vector;
                  redir_pc_d = exc_vector;
                  src_d      = SRC_EXC;
               end else begin
                  redir_pc_d = pend_q;
                  src_d      = SRC_BR;
               end
               state_d       = ST_FLUSH;
               cmt_ready_d   = 1'b0;
               flush_d       = 1'b1;
               redir_valid_d = 1'b1;
               tmr_load      = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (tmr_done) begin
               flush_d = 1'b0;
               if (!redir_valid_q || redir_ready) begin
                  state_d     = ST_IDLE;
                  cmt_ready_d = 1'b1;
               end else begin
                  state_d = ST_REDIR;
               end
            end
         end
         ST_REDIR: begin
            if (redir_ready) begin
               state_d     = ST_IDLE;
               cmt_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         src_q         <= SRC_BR;
         cmt_ready_q   <= 1'b1;
         flush_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         pend_q        <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         cmt_ready_q   <= cmt_ready_d;
         flush_q       <= flush_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         pend_q        <= pend_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmt_ready    = cmt_ready_q;
   assign flush        = flush_q;
   assign redir_valid  = redir_valid_q;
   assign redir_pc     = redir_pc_q;
   assign br_taken_cnt = cnt_q;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed scenarios plus random commits, checked every cycle against a
// timeline model (event cycle, acceptance cycle) of the redirect controller.
module tb_br_redirect_ctrl;

   localparam int unsigned FC = 2;
   localparam int unsigned CW = 32;

   logic          clk;
   logic          resetn;
   logic          cmt_valid, cmt_is_br, cmt_br_e, cmt_exc, redir_ready;
   logic [31:0]   cmt_target, exc_vector;
   logic          cmt_ready, flush, redir_valid;
   logic [31:0]   redir_pc;
   logic [CW-1:0] br_taken_cnt;

   int n_cmp;
   int n_bad;

   // Model: a redirect event fires at cycle m_ev; fetch accepts at m_acc (-1 = not yet).
   int          cyc;
   int          m_ev;
   int          m_acc;
   bit          m_evv;
   bit          m_wait;
   bit          m_src_br;
   logic [31:0] m_pc, m_tgt, m_cnt;
   bit          e_busy, e_flush, e_valid, e_ready;

   br_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_WD(CW)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .cmt_valid    (cmt_valid),
      .cmt_is_br    (cmt_is_br),
      .cmt_br_e     (cmt_br_e),
      .cmt_target   (cmt_target),
      .cmt_exc      (cmt_exc),
      .exc_vector   (exc_vector),
      .cmt_ready    (cmt_ready),
      .flush        (flush),
      .redir_valid  (redir_valid),
      .redir_pc     (redir_pc),
      .redir_ready  (redir_ready),
      .br_taken_cnt (br_taken_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_evv  = 1'b0;
      m_ev   = 0;
      m_acc  = -1;
      m_wait = 1'b0;
      m_cnt  = '0;
      m_pc   = '0;
      m_tgt  = '0;
   endtask

   task automatic model_eval();
      e_flush = m_evv && (cyc <= m_ev + int'(FC));
      e_valid = m_evv && (m_acc < 0 || cyc <= m_acc);
      e_busy  = e_flush || e_valid;
      e_ready = !e_busy;
   endtask

   // Called at a negedge: drive, compare, clock, advance model.
   task automatic step(input bit v, input bit br, input bit bre, input logic [31:0] tgt,
                       input bit exc, input logic [31:0] vec, input bit rdy);
      bit fire;
      cmt_valid   = v;
      cmt_is_br   = br;
      cmt_br_e    = bre;
      cmt_target  = tgt;
      cmt_exc     = exc;
      exc_vector  = vec;
      redir_ready = rdy;
      model_eval();
      chk("cmt_ready", 32'(cmt_ready), 32'(e_ready));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("redir_valid", 32'(redir_valid), 32'(e_valid));
      chk("br_taken_cnt", br_taken_cnt, m_cnt);
      if (e_valid) chk("redir_pc", redir_pc, m_pc);
      @(posedge clk);
      fire = v && e_ready;
      if (e_valid && rdy && m_acc < 0) begin
         m_acc = cyc;
         if (m_src_br) m_cnt = m_cnt + 32'd1;
      end
      if (fire) begin
         if (m_wait || exc) begin
            m_evv    = 1'b1;
            m_ev     = cyc;
            m_acc    = -1;
            m_src_br = !exc;
            m_pc     = exc ? vec : m_tgt;
            m_wait   = 1'b0;
         end else if (br && bre) begin
            m_wait = 1'b1;
            m_tgt  = tgt;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
   endtask

   task automatic normal(input bit rdy);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      model_reset();
      resetn      = 1'b0;
      cmt_valid   = 1'b0;
      cmt_is_br   = 1'b0;
      cmt_br_e    = 1'b0;
      cmt_target  = '0;
      cmt_exc     = 1'b0;
      exc_vector  = '0;
      redir_ready = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Reset state
      chk("rst cmt_ready", 32'(cmt_ready), 32'd1);
      chk("rst flush", 32'(flush), 32'd0);
      chk("rst redir_valid", 32'(redir_valid), 32'd0);
      chk("rst redir_pc", redir_pc, 32'd0);
      chk("rst cnt", br_taken_cnt, 32'd0);

      // 1: taken beq, delay slot next cycle, fetch ready
      step(1'b1, 1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b1);
      normal(1'b1);
      chk("t1 flush N+1", 32'(flush), 32'd1);
      chk("t1 rv N+1", 32'(redir_valid), 32'd1);
      chk("t1 pc N+1", redir_pc, 32'hBFC0_0100);
      chk("t1 model pc", m_pc, 32'hBFC0_0100);
      chk("t1 ready N+1", 32'(cmt_ready), 32'd0);
      idle(1'b1);
      chk("t1 flush N+2", 32'(flush), 32'd1);
      chk("t1 rv N+2", 32'(redir_valid), 32'd0);
      chk("t1 cnt", br_taken_cnt, 32'd1);
      chk("t1 model cnt", m_cnt, 32'd1);
      idle(1'b1);
      chk("t1 ready N+3", 32'(cmt_ready), 32'd1);
      chk("t1 flush N+3", 32'(flush), 32'd0);

      // 2: not-taken bne then five normal commits
      step(1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         normal(1'b1);
         chk("t2 ready", 32'(cmt_ready), 32'd1);
         chk("t2 flush", 32'(flush), 32'd0);
         chk("t2 rv", 32'(redir_valid), 32'd0);
      end

      // 3: taken jal, delay slot arrives after 4 idle cycles
      step(1'b1, 1'b1, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         chk("t3 wait flush", 32'(flush), 32'd0);
         chk("t3 wait ready", 32'(cmt_ready), 32'd1);
      end
      normal(1'b1);
      chk("t3 flush", 32'(flush), 32'd1);
      chk("t3 pc", redir_pc, 32'h8000_2000);
      repeat (2) idle(1'b1);
      chk("t3 cnt", br_taken_cnt, 32'd2);

      // 4: taken jr whose delay slot raises an exception
      step(1'b1, 1'b1, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b1);
      chk("t4 pc", redir_pc, 32'hBFC0_0380);
      chk("t4 rv", 32'(redir_valid), 32'd1);
      repeat (2) idle(1'b1);
      chk("t4 cnt", br_taken_cnt, 32'd2);

      // 5: fetch stalls the redirect for six cycles
      step(1'b1, 1'b1, 1'b1, 32'h9000_0010, 1'b0, 32'h0, 1'b0);
      normal(1'b0);
      for (int i = 0; i < 6; i++) begin
         chk("t5 rv", 32'(redir_valid), 32'd1);
         chk("t5 pc", redir_pc, 32'h9000_0010);
         chk("t5 ready", 32'(cmt_ready), 32'd0);
         chk("t5 flush", 32'(flush), (i < int'(FC)) ? 32'd1 : 32'd0);
         idle(1'b0);
      end
      idle(1'b1);
      chk("t5 ready after acc", 32'(cmt_ready), 32'd1);
      chk("t5 rv after acc", 32'(redir_valid), 32'd0);
      chk("t5 cnt", br_taken_cnt, 32'd3);

      // 6: asynchronous reset during FLUSH with a redirect pending
      step(1'b1, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b0);
      normal(1'b0);
      chk("t6 pre rv", 32'(redir_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("t6 async flush", 32'(flush), 32'd0);
      chk("t6 async rv", 32'(redir_valid), 32'd0);
      chk("t6 async ready", 32'(cmt_ready), 32'd1);
      chk("t6 async cnt", br_taken_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      cyc++;
      resetn = 1'b1;
      step(1'b1, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0, 1'b1);
      normal(1'b1);
      chk("t6 pc", redir_pc, 32'hBFC0_0200);
      chk("t6 flush", 32'(flush), 32'd1);
      repeat (2) idle(1'b1);
      chk("t6 cnt", br_taken_cnt, 32'd1);

      // Random commit streams against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              32'($urandom), $urandom_range(0, 15) == 0, 32'($urandom),
              $urandom_range(0, 2) != 0);
      end
      repeat (8) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
